captura_numeros: RTL and testbench

Keypad-entry front end for the BCD adder stage. It takes one-cycle key strobes from the keypad scanner and assembles two 4-digit BCD operands. It pulses `suma` to start the adder, waits for the adder's `ent` handshake, and pulses `finalizar` to clear the adder on a new operation or an explicit clear. It sits directly upstream of the adder and drives its `numero_sv`, `numero`, `suma` and `finalizar` inputs.

---
 rtl/captura_numeros_if.sv | 20 ++
 rtl/captura_numeros.sv | 91 +++++++++
 tb/tb_captura_numeros.sv | 83 ++++++++
 3 files changed

// File: rtl/captura_numeros_if.sv
// captura_numeros_if: keypad strobes in, BCD operands and adder handshake out
interface captura_numeros_if;
  logic            tecla_valida;
  logic [3:0]      tecla;
  logic            ent;
  logic [3:0][3:0] numero;
  logic [3:0][3:0] numero_sv;
  logic            suma;
  logic            finalizar;
  logic [2:0]      digitos;
  logic [1:0]      estado;
  modport master (
    output tecla_valida, tecla, ent,
    input  numero, numero_sv, suma, finalizar, digitos, estado
  );
  modport slave (
    input  tecla_valida, tecla, ent,
    output numero, numero_sv, suma, finalizar, digitos, estado
  );
endinterface

// File: rtl/captura_numeros.sv
// captura_numeros: assembles two 4-digit BCD operands from keypad strobes and drives the adder handshake
module captura_numeros #(
  parameter logic [3:0] TECLA_SUMA   = 4'hA,
  parameter logic [3:0] TECLA_IGUAL  = 4'hB,
  parameter logic [3:0] TECLA_BORRAR = 4'hC
) (
  input logic clk,
  input logic rst,
  captura_numeros_if.slave bus
);
  typedef enum logic [1:0] {ENTRADA_A, ENTRADA_B, ESPERA, MOSTRAR} estado_t;
  estado_t         estado_q, estado_d;
  logic [3:0][3:0] numero_q, numero_d;
  logic [3:0][3:0] numero_sv_q, numero_sv_d;
  logic            suma_q, suma_d;
  logic            finalizar_q, finalizar_d;
  logic [2:0]      digitos_q, digitos_d;
  logic            es_digito, es_suma, es_igual, es_borrar;
  assign es_digito = bus.tecla_valida && (bus.tecla <= 4'd9);
  assign es_suma   = bus.tecla_valida && (bus.tecla == TECLA_SUMA);
  assign es_igual  = bus.tecla_valida && (bus.tecla == TECLA_IGUAL);
  assign es_borrar = bus.tecla_valida && (bus.tecla == TECLA_BORRAR);
  // next state: clear overrides everything, including ent in ESPERA; pulses default low
  always_comb begin
    estado_d    = estado_q;
    numero_d    = numero_q;
    numero_sv_d = numero_sv_q;
    digitos_d   = digitos_q;
    suma_d      = 1'b0;
    finalizar_d = 1'b0;
    if (es_borrar) begin
      finalizar_d = 1'b1;
      numero_d    = '0;
      numero_sv_d = '0;
      digitos_d   = '0;
      estado_d    = ENTRADA_A;
    end else begin
      case (estado_q)
        ENTRADA_A, ENTRADA_B: begin
          if (es_digito && digitos_q < 3'd4) begin
            numero_d  = {numero_q[2:0], bus.tecla};
            digitos_d = digitos_q + 3'd1;
          end else if (es_suma && estado_q == ENTRADA_A) begin
            numero_sv_d = numero_q;
            numero_d    = '0;
            digitos_d   = '0;
            estado_d    = ENTRADA_B;
          end else if (es_igual && estado_q == ENTRADA_B) begin
            suma_d   = 1'b1;
            estado_d = ESPERA;
          end
        end
        ESPERA: estado_d = bus.ent ? MOSTRAR : ESPERA;
        MOSTRAR: begin
          if (es_digito) begin
            finalizar_d = 1'b1;
            numero_sv_d = '0;
            numero_d    = {12'h000, bus.tecla};
            digitos_d   = 3'd1;
            estado_d    = ENTRADA_A;
          end
        end
        default: estado_d = ENTRADA_A;
      endcase
    end
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q    <= ENTRADA_A;
      numero_q    <= '0;
      numero_sv_q <= '0;
      digitos_q   <= '0;
      suma_q      <= 1'b0;
      finalizar_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      numero_q    <= numero_d;
      numero_sv_q <= numero_sv_d;
      digitos_q   <= digitos_d;
      suma_q      <= suma_d;
      finalizar_q <= finalizar_d;
    end
  end
  assign bus.numero    = numero_q;
  assign bus.numero_sv = numero_sv_q;
  assign bus.digitos   = digitos_q;
  assign bus.suma      = suma_q;
  assign bus.finalizar = finalizar_q;
  assign bus.estado    = estado_q;
endmodule

// File: tb/tb_captura_numeros.sv
// tb_captura_numeros: directed keypad sequences against hand-computed operand and handshake values
module tb_captura_numeros;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  captura_numeros_if bus ();
  captura_numeros dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic state(input string tag, input logic [15:0] num, input logic [15:0] sv,
                       input logic [2:0] dig, input logic [1:0] est, input logic s, input logic f);
    chk({tag, ".numero"}, bus.numero, num);
    chk({tag, ".numero_sv"}, bus.numero_sv, sv);
    chk({tag, ".digitos"}, bus.digitos, dig);
    chk({tag, ".estado"}, bus.estado, est);
    chk({tag, ".suma"}, bus.suma, s);
    chk({tag, ".finalizar"}, bus.finalizar, f);
  endtask
  task automatic press(input logic [3:0] k);
    bus.tecla = k;
    bus.tecla_valida = 1'b1;
    @(negedge clk);
    bus.tecla_valida = 1'b0;
  endtask
  task automatic idle();
    @(negedge clk);
  endtask
  initial begin
    bus.tecla_valida = 1'b0;
    bus.tecla = 4'h0;
    bus.ent = 1'b0;
    repeat (3) @(negedge clk);
    state("reset", 16'h0, 16'h0, 3'd0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    press(4'd1); state("d1", 16'h0001, 16'h0, 3'd1, 2'd0, 1'b0, 1'b0);
    press(4'd2); state("d2", 16'h0012, 16'h0, 3'd2, 2'd0, 1'b0, 1'b0);
    press(4'd3); state("d3", 16'h0123, 16'h0, 3'd3, 2'd0, 1'b0, 1'b0);
    press(4'hC); state("clr", 16'h0, 16'h0, 3'd0, 2'd0, 1'b0, 1'b1);
    idle();      state("clr_end", 16'h0, 16'h0, 3'd0, 2'd0, 1'b0, 1'b0);
    press(4'd9); press(4'd8); press(4'd7); press(4'd6);
    state("ovf4", 16'h9876, 16'h0, 3'd4, 2'd0, 1'b0, 1'b0);
    press(4'd5); state("ovf5", 16'h9876, 16'h0, 3'd4, 2'd0, 1'b0, 1'b0);
    press(4'hE); state("keyE_a", 16'h9876, 16'h0, 3'd4, 2'd0, 1'b0, 1'b0);
    press(4'hB); state("eq_in_a", 16'h9876, 16'h0, 3'd4, 2'd0, 1'b0, 1'b0);
    press(4'hC); idle();
    press(4'd1); press(4'd2);
    press(4'hA); state("plus", 16'h0, 16'h0012, 3'd0, 2'd1, 1'b0, 1'b0);
    press(4'hA); state("plus_in_b", 16'h0, 16'h0012, 3'd0, 2'd1, 1'b0, 1'b0);
    press(4'd3); press(4'd4);
    state("b34", 16'h0034, 16'h0012, 3'd2, 2'd1, 1'b0, 1'b0);
    press(4'hE); state("keyE_b", 16'h0034, 16'h0012, 3'd2, 2'd1, 1'b0, 1'b0);
    press(4'hB); state("eq", 16'h0034, 16'h0012, 3'd2, 2'd2, 1'b1, 1'b0);
    bus.ent = 1'b1;
    idle();      state("ent", 16'h0034, 16'h0012, 3'd2, 2'd3, 1'b0, 1'b0);
    bus.ent = 1'b0;
    press(4'hA); state("plus_mostrar", 16'h0034, 16'h0012, 3'd2, 2'd3, 1'b0, 1'b0);
    press(4'd7); state("new_op", 16'h0007, 16'h0, 3'd1, 2'd0, 1'b0, 1'b1);
    idle();      state("new_op_end", 16'h0007, 16'h0, 3'd1, 2'd0, 1'b0, 1'b0);
    press(4'hC); press(4'd1); press(4'hA); press(4'd2); press(4'hB);
    idle();      state("espera", 16'h0002, 16'h0001, 3'd1, 2'd2, 1'b0, 1'b0);
    press(4'd5); state("dig_espera", 16'h0002, 16'h0001, 3'd1, 2'd2, 1'b0, 1'b0);
    bus.ent = 1'b1;
    press(4'hC); state("clr_vs_ent", 16'h0, 16'h0, 3'd0, 2'd0, 1'b0, 1'b1);
    bus.ent = 1'b0;
    press(4'd1); press(4'hA); press(4'd2); press(4'hB);
    chk("pre_rst.suma", bus.suma, 1'b1);
    #1 rst = 1'b1;
    #1 state("async_rst", 16'h0, 16'h0, 3'd0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    state("rst_hold", 16'h0, 16'h0, 3'd0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    idle();      state("post_rst", 16'h0, 16'h0, 3'd0, 2'd0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
